binary_morph_nxn: RTL and testbench



---
 rtl/binary_morph_pkg.sv | 15 +
 rtl/morph_line_buffer.sv | 27 ++
 rtl/binary_morph_nxn.sv | 165 ++++++++++++++++
 tb/tb_binary_morph_nxn.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/binary_morph_pkg.sv
// Shared constants and elaboration helpers for the binary morphology stage.
package binary_morph_pkg;

  localparam logic MORPH_DILATE = 1'b0;
  localparam logic MORPH_ERODE  = 1'b1;

  // Pipeline depth from pre_* to post_*.
  localparam int unsigned LAT = 2;

  // Only 3x3 and 5x5 structuring elements are supported.
  function automatic bit ksize_is_legal(input int unsigned ksize);
    return (ksize == 3) || (ksize == 5);
  endfunction

endpackage

// File: rtl/morph_line_buffer.sv
// Per-column history of the previous KSIZE-1 rows. Each write shifts the
// column entry by one row and inserts the current pixel at bit 0.
module morph_line_buffer #(
  parameter int unsigned DEPTH  = 640,
  parameter int unsigned WIDTH  = 2,
  parameter int unsigned ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk_i,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic              bit_i,
  output logic [WIDTH-1:0]  rdata_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  // Asynchronous read; bit j holds the pixel j+1 rows above the current one.
  assign rdata_o = mem_q[addr_i];

  // Shift-write: drop the oldest row, append the current pixel.
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[addr_i] <= {rdata_o[WIDTH-2:0], bit_i};
    end
  end

endmodule

// File: rtl/binary_morph_nxn.sv
// KxK binary dilation/erosion with own line storage and border handling.
// The result is anchored at the bottom-right of the window, i.e. shifted by
// (KSIZE-1)/2 rows and columns relative to a centred kernel.
module binary_morph_nxn
  import binary_morph_pkg::*;
#(
  parameter int unsigned IMG_W = 640,
  parameter int unsigned KSIZE = 3,
  parameter int unsigned COL_W = $clog2(IMG_W)
) (
  input  logic clk_i,
  input  logic rst_n,
  input  logic mode_i,
  input  logic pre_frame_vsync_i,
  input  logic pre_frame_href_i,
  input  logic pre_frame_clken_i,
  input  logic pre_img_bit_i,
  output logic post_frame_vsync_o,
  output logic post_frame_href_o,
  output logic post_frame_clken_o,
  output logic post_img_bit_o
);

  if (!ksize_is_legal(KSIZE)) begin : g_ksize_check
    $error("binary_morph_nxn: KSIZE must be 3 or 5");
  end

  localparam int unsigned       HistW  = KSIZE - 1;
  localparam logic [COL_W-1:0]  ColMax = COL_W'(IMG_W - 1);
  localparam logic [2:0]        RowMax = 3'(KSIZE - 1);

  logic             vsync_prev_q, href_prev_q;
  logic             mode_q, framed_q;
  logic [2:0]       row_q;
  logic [COL_W-1:0] col_q;
  logic             col_ovf_q;
  logic [LAT-1:0]   vs_pipe_q, hr_pipe_q, ck_pipe_q;

  logic             vs_rise, href_rise, href_fall, pix_en, mem_we;
  logic [HistW-1:0] hist_rd, hist_msk;
  logic [KSIZE-1:0] col_new;
  logic [KSIZE-1:0] win_base [KSIZE];
  logic [KSIZE-1:0] win_d    [KSIZE];
  logic [KSIZE-1:0] win_q    [KSIZE];
  logic [KSIZE-1:0] col_red_d, col_red_q;
  logic             res_q;

  assign vs_rise   = pre_frame_vsync_i & ~vsync_prev_q;
  assign href_rise = pre_frame_href_i & ~href_prev_q;
  assign href_fall = ~pre_frame_href_i & href_prev_q;
  assign pix_en    = pre_frame_clken_i & pre_frame_href_i;
  // Beats past the last column are still processed but never stored.
  assign mem_we    = pix_en & ~col_ovf_q;

  // Edge detection, per-frame mode latch and row/column counters.
  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      vsync_prev_q <= 1'b0;
      href_prev_q  <= 1'b0;
      mode_q       <= MORPH_DILATE;
      framed_q     <= 1'b0;
      row_q        <= '0;
      col_q        <= '0;
      col_ovf_q    <= 1'b0;
    end else begin
      vsync_prev_q <= pre_frame_vsync_i;
      href_prev_q  <= pre_frame_href_i;
      if (vs_rise) begin
        mode_q   <= mode_i;
        framed_q <= 1'b1;
      end
      // Row stays 0 after reset until a frame start is seen.
      if (vs_rise) begin
        row_q <= '0;
      end else if (href_fall && framed_q && (row_q != RowMax)) begin
        row_q <= row_q + 3'd1;
      end
      if (href_fall) begin
        col_q     <= '0;
        col_ovf_q <= 1'b0;
      end else if (pix_en) begin
        if (col_q == ColMax) begin
          col_ovf_q <= 1'b1;
        end else begin
          col_q <= col_q + COL_W'(1);
        end
      end
    end
  end

  morph_line_buffer #(
    .DEPTH  (IMG_W),
    .WIDTH  (HistW),
    .ADDR_W (COL_W)
  ) u_line_buffer (
    .clk_i   (clk_i),
    .we_i    (mem_we),
    .addr_i  (col_q),
    .bit_i   (pre_img_bit_i),
    .rdata_o (hist_rd)
  );

  // Rows above the frame top read the neutral value; stale memory is hidden.
  always_comb begin
    hist_msk = '0;
    for (int j = 0; j < int'(HistW); j++) begin
      hist_msk[j] = (3'(j) < row_q) ? hist_rd[j] : mode_q;
    end
    col_new = {hist_msk, pre_img_bit_i};
  end

  // Window next state: neutral preset at line start, then shift on each beat.
  always_comb begin
    for (int k = 0; k < int'(KSIZE); k++) begin
      win_base[k] = href_rise ? {KSIZE{mode_q}} : win_q[k];
      win_d[k]    = win_base[k];
    end
    if (pix_en) begin
      win_d[0] = col_new;
      for (int k = 1; k < int'(KSIZE); k++) begin
        win_d[k] = win_base[k-1];
      end
    end
    col_red_d = '0;
    for (int k = 0; k < int'(KSIZE); k++) begin
      col_red_d[k] = mode_q ? (&win_d[k]) : (|win_d[k]);
    end
  end

  // Window storage and the two reduction stages.
  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < int'(KSIZE); k++) begin
        win_q[k] <= '0;
      end
      col_red_q <= '0;
      res_q     <= 1'b0;
    end else begin
      for (int k = 0; k < int'(KSIZE); k++) begin
        win_q[k] <= win_d[k];
      end
      col_red_q <= col_red_d;
      res_q     <= mode_q ? (&col_red_q) : (|col_red_q);
    end
  end

  // Sync signals follow the data through an equal-depth register chain.
  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      vs_pipe_q <= '0;
      hr_pipe_q <= '0;
      ck_pipe_q <= '0;
    end else begin
      vs_pipe_q <= {vs_pipe_q[LAT-2:0], pre_frame_vsync_i};
      hr_pipe_q <= {hr_pipe_q[LAT-2:0], pre_frame_href_i};
      ck_pipe_q <= {ck_pipe_q[LAT-2:0], pre_frame_clken_i};
    end
  end

  assign post_frame_vsync_o = vs_pipe_q[LAT-1];
  assign post_frame_href_o  = hr_pipe_q[LAT-1];
  assign post_frame_clken_o = ck_pipe_q[LAT-1];
  assign post_img_bit_o     = res_q;

endmodule

// File: tb/tb_binary_morph_nxn.sv
// Self-checking bench: a 3x3 and a 5x5 instance share one input stream and are
// compared against a 2-D neighbourhood reference and a 2-cycle sync model.
module tb_binary_morph_nxn;

  localparam int W = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n, mode, vs, hr, ck, px;
  logic p3_vs, p3_hr, p3_ck, p3_px;
  logic p5_vs, p5_hr, p5_ck, p5_px;

  binary_morph_nxn #(.IMG_W(W), .KSIZE(3)) u_k3 (
    .clk_i(clk), .rst_n(rst_n), .mode_i(mode),
    .pre_frame_vsync_i(vs), .pre_frame_href_i(hr), .pre_frame_clken_i(ck),
    .pre_img_bit_i(px),
    .post_frame_vsync_o(p3_vs), .post_frame_href_o(p3_hr),
    .post_frame_clken_o(p3_ck), .post_img_bit_o(p3_px)
  );

  binary_morph_nxn #(.IMG_W(W), .KSIZE(5)) u_k5 (
    .clk_i(clk), .rst_n(rst_n), .mode_i(mode),
    .pre_frame_vsync_i(vs), .pre_frame_href_i(hr), .pre_frame_clken_i(ck),
    .pre_img_bit_i(px),
    .post_frame_vsync_o(p5_vs), .post_frame_href_o(p5_hr),
    .post_frame_clken_o(p5_ck), .post_img_bit_o(p5_px)
  );

  int checks = 0;
  int errors = 0;
  bit img [16][16];
  logic frame_mode;
  int expq0[$];
  int expq1[$];
  int cnt[2];
  int ones[2];
  logic [2:0] d_cur, d_prev;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: reduce the KxK neighbourhood ending at (r,c); outside -> neutral.
  function automatic int ref_px(input int k, input int r, input int c, input logic n);
    logic acc, v;
    if (c >= W) return -1;
    acc = n;
    for (int i = 0; i < k; i++) begin
      for (int j = 0; j < k; j++) begin
        v   = (r - i < 0 || c - j < 0) ? n : logic'(img[r-i][c-j]);
        acc = n ? (acc & v) : (acc | v);
      end
    end
    return int'(acc);
  endfunction

  function automatic logic pix(input int pat, input int r, input int c);
    case (pat)
      1:       return (r == 3 && c == 3);
      2:       return 1'b1;
      3:       return !(r == 4 && c == 4);
      4:       return ($urandom_range(0, 3) == 0);
      5:       return ($urandom_range(0, 7) != 0);
      default: return logic'($urandom_range(0, 1));
    endcase
  endfunction

  task automatic sample();
    logic [3:0] o [2];
    int e;
    o[0] = {p3_vs, p3_hr, p3_ck, p3_px};
    o[1] = {p5_vs, p5_hr, p5_ck, p5_px};
    for (int k = 0; k < 2; k++) begin
      chk(k == 0 ? "sync_k3" : "sync_k5", 32'(o[k][3:1]), 32'(d_prev));
      if (o[k][1] === 1'b1) begin
        cnt[k]++;
        if (o[k][0] === 1'b1) ones[k]++;
        if (k == 0) begin
          chk("q_nonempty_k3", 32'(expq0.size() != 0), 32'd1);
          e = (expq0.size() != 0) ? expq0.pop_front() : -1;
        end else begin
          chk("q_nonempty_k5", 32'(expq1.size() != 0), 32'd1);
          e = (expq1.size() != 0) ? expq1.pop_front() : -1;
        end
        if (e >= 0) chk(k == 0 ? "pix_k3" : "pix_k5", 32'(o[k][0]), 32'(e));
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    sample();
    d_prev = d_cur;
  endtask

  task automatic cyc(input logic v, input logic h, input logic c, input logic b);
    vs = v; hr = h; ck = c; px = b;
    d_cur = {v, h, c};
    tick();
  endtask

  task automatic do_reset();
    #2;
    rst_n = 1'b0;
    vs = 1'b0; hr = 1'b0; ck = 1'b0; px = 1'b0;
    #1;
    chk("rst_async_k3", 32'({p3_vs, p3_hr, p3_ck, p3_px}), 32'd0);
    chk("rst_async_k5", 32'({p5_vs, p5_hr, p5_ck, p5_px}), 32'd0);
    expq0.delete();
    expq1.delete();
    d_cur  = '0;
    d_prev = '0;
    repeat (3) cyc(1'b0, 1'b0, 1'b0, 1'b0);
    rst_n = 1'b1;
    repeat (3) cyc(1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic run_frame(input int h, input int pat, input bit gaps, input int flip_row,
                           input int long_row, input int rst_row);
    int len, c;
    logic b;
    cnt  = '{0, 0};
    ones = '{0, 0};
    frame_mode = mode;
    cyc(1'b1, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b0, 1'b0);
    for (int r = 0; r < h; r++) begin
      if (r == flip_row) mode = ~mode;
      len = (r == long_row) ? W + 2 : W;
      c = 0;
      while (c < len) begin
        if (r == rst_row && c == 2) begin
          do_reset();
          return;
        end
        if (gaps && $urandom_range(0, 1) == 0) begin
          cyc(1'b0, 1'b1, 1'b0, logic'($urandom_range(0, 1)));
        end else begin
          b = pix(pat, r, c);
          if (c < W) img[r][c] = b;
          expq0.push_back(ref_px(3, r, c, frame_mode));
          expq1.push_back(ref_px(5, r, c, frame_mode));
          cyc(1'b0, 1'b1, 1'b1, b);
          c++;
        end
      end
      cyc(1'b0, 1'b0, 1'b0, 1'b0);
    end
    repeat (4) cyc(1'b0, 1'b0, 1'b0, 1'b0);
    chk("drain_k3", 32'(expq0.size()), 32'd0);
    chk("drain_k5", 32'(expq1.size()), 32'd0);
  endtask

  initial begin
    rst_n = 1'b0; mode = 1'b0;
    vs = 1'b0; hr = 1'b0; ck = 1'b0; px = 1'b0;
    d_cur = '0; d_prev = '0;
    cnt = '{0, 0}; ones = '{0, 0};
    repeat (3) tick();
    chk("reset_k3", 32'({p3_vs, p3_hr, p3_ck, p3_px}), 32'd0);
    chk("reset_k5", 32'({p5_vs, p5_hr, p5_ck, p5_px}), 32'd0);
    rst_n = 1'b1;
    repeat (2) cyc(1'b0, 1'b0, 1'b0, 1'b0);

    // Isolated pixel, dilate.
    mode = 1'b0;
    run_frame(8, 1, 1'b0, -1, -1, -1);
    chk("single_clken_count_k3", 32'(cnt[0]), 32'd64);
    chk("single_ones_k3", 32'(ones[0]), 32'd9);
    chk("single_ones_k5", 32'(ones[1]), 32'd25);

    // All ones, erode: borders read neutral 1.
    mode = 1'b1;
    run_frame(8, 2, 1'b0, -1, -1, -1);
    chk("allones_k3", 32'(ones[0]), 32'd64);
    chk("allones_k5", 32'(ones[1]), 32'd64);

    // One hole at (4,4), erode.
    run_frame(8, 3, 1'b0, -1, -1, -1);
    chk("hole_ones_k5", 32'(ones[1]), 32'd48);

    // Random clken gaps, both modes.
    mode = 1'b0;
    run_frame(8, 4, 1'b1, -1, -1, -1);
    mode = 1'b1;
    run_frame(8, 5, 1'b1, -1, -1, -1);

    // Mode flips mid-frame: current frame dilates, next erodes.
    mode = 1'b0;
    run_frame(8, 4, 1'b0, 2, -1, -1);
    run_frame(8, 5, 1'b0, -1, -1, -1);

    // Overlong line at row 3.
    mode = 1'b0;
    run_frame(8, 4, 1'b0, -1, 3, -1);
    chk("long_count_k3", 32'(cnt[0]), 32'd66);
    chk("long_count_k5", 32'(cnt[1]), 32'd66);

    // Reset mid-frame, then clean frames.
    run_frame(8, 4, 1'b0, -1, -1, 4);
    run_frame(8, 4, 1'b1, -1, -1, -1);
    mode = 1'b1;
    run_frame(8, 5, 1'b1, -1, -1, -1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
